// File: rtl/rv32i_regfile_pkg.sv
// Shared widths, register constants and the operand-select helper for the RV32I
// register-file access path.
package rv32i_regfile_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    // x0 is hard-wired to zero; a write landing this cycle beats the stale file value.
    function automatic logic [XLEN-1:0] read_src(
        input logic [REG_ADDR_W-1:0] src,
        input logic [XLEN-1:0]       file_data,
        input logic                  we,
        input logic [REG_ADDR_W-1:0] wsel,
        input logic [XLEN-1:0]       wdata
    );
        if (src == REG_X0) return '0;
        if (we && wsel == src) return wdata;
        return file_data;
    endfunction
endpackage

// File: rtl/writeback_fifo.sv
// Writeback FIFO: power-of-two ring with one extra pointer bit to tell full from
// empty; the head entry is presented combinationally.
module writeback_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]                 wr_ptr, rd_ptr;
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic                        do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/regfile_access_controller.sv
// Register-file initiator: issues operand reads with scoreboard hazard checks and
// forwarding, and drains buffered writebacks into the file one per cycle.
module regfile_access_controller
    import rv32i_regfile_pkg::*;
#(
    parameter int WB_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_writes_rd,
    output logic                  operand_valid,
    input  logic                  operand_ready,
    output logic [XLEN-1:0]       operand_a,
    output logic [XLEN-1:0]       operand_b,
    output logic [REG_ADDR_W-1:0] operand_rd,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic [REG_ADDR_W-1:0] rs1,
    output logic [REG_ADDR_W-1:0] rs2,
    input  logic [XLEN-1:0]       register_data_1,
    input  logic [XLEN-1:0]       register_data_2,
    output logic                  write_enable,
    output logic [REG_ADDR_W-1:0] register_write_select,
    output logic [XLEN-1:0]       register_data_write
);
    wb_entry_t           push_entry, head_entry;
    logic                fifo_full, fifo_empty, wb_push;
    logic [NUM_REGS-1:0] pending, pending_nxt;
    logic                raw_1, raw_2, waw, accept;

    assign rs1 = issue_rs1;
    assign rs2 = issue_rs2;

    assign wb_ready   = !fifo_full;
    assign wb_push    = wb_valid && !fifo_full && (wb_rd != REG_X0);
    assign push_entry = '{rd: wb_rd, data: wb_data};

    // Draining is held off while reset is low so the reset cycle never writes the file.
    assign write_enable          = !fifo_empty && reset;
    assign register_write_select = head_entry.rd;
    assign register_data_write   = head_entry.data;

    writeback_fifo #(
        .WIDTH($bits(wb_entry_t)),
        .DEPTH(WB_DEPTH)
    ) u_wb_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (wb_push),
        .push_data(push_entry),
        .pop      (write_enable),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head_entry)
    );

    // A RAW hazard resolves in the cycle the head writes the source; WAW waits a cycle more.
    assign raw_1 = (issue_rs1 != REG_X0) && pending[issue_rs1] &&
                   !(write_enable && register_write_select == issue_rs1);
    assign raw_2 = (issue_rs2 != REG_X0) && pending[issue_rs2] &&
                   !(write_enable && register_write_select == issue_rs2);
    assign waw   = issue_writes_rd && (issue_rd != REG_X0) && pending[issue_rd];

    assign issue_ready = (!operand_valid || operand_ready) && !raw_1 && !raw_2 && !waw;
    assign accept      = issue_valid && issue_ready;

    always_comb begin
        pending_nxt = pending;
        if (write_enable) pending_nxt[register_write_select] = 1'b0;
        if (accept && issue_writes_rd) pending_nxt[issue_rd] = 1'b1;
        pending_nxt[REG_X0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pending       <= '0;
            operand_valid <= 1'b0;
            operand_a     <= '0;
            operand_b     <= '0;
            operand_rd    <= '0;
        end else begin
            pending <= pending_nxt;
            if (accept) begin
                operand_valid <= 1'b1;
                operand_a     <= read_src(issue_rs1, register_data_1, write_enable,
                                          register_write_select, register_data_write);
                operand_b     <= read_src(issue_rs2, register_data_2, write_enable,
                                          register_write_select, register_data_write);
                operand_rd    <= issue_rd;
            end else if (operand_ready) begin
                operand_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_access_controller.sv
// Bench for regfile_access_controller: reset checks, a randomized run against a
// queue-based reference model, a vector table, and directed multi-cycle sequences.
module tb_regfile_access_controller;
    import rv32i_regfile_pkg::*;

    localparam int WB_DEPTH = 4;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  issue_valid, issue_ready, issue_writes_rd;
    logic [REG_ADDR_W-1:0] issue_rs1, issue_rs2, issue_rd;
    logic                  operand_valid, operand_ready;
    logic [XLEN-1:0]       operand_a, operand_b;
    logic [REG_ADDR_W-1:0] operand_rd;
    logic                  wb_valid, wb_ready;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;
    logic [REG_ADDR_W-1:0] rs1, rs2;
    logic [XLEN-1:0]       register_data_1, register_data_2;
    logic                  write_enable;
    logic [REG_ADDR_W-1:0] register_write_select;
    logic [XLEN-1:0]       register_data_write;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    regfile_access_controller #(.WB_DEPTH(WB_DEPTH)) dut (
        .clock                (clock),
        .reset                (reset),
        .issue_valid          (issue_valid),
        .issue_ready          (issue_ready),
        .issue_rs1            (issue_rs1),
        .issue_rs2            (issue_rs2),
        .issue_rd             (issue_rd),
        .issue_writes_rd      (issue_writes_rd),
        .operand_valid        (operand_valid),
        .operand_ready        (operand_ready),
        .operand_a            (operand_a),
        .operand_b            (operand_b),
        .operand_rd           (operand_rd),
        .wb_valid             (wb_valid),
        .wb_ready             (wb_ready),
        .wb_rd                (wb_rd),
        .wb_data              (wb_data),
        .rs1                  (rs1),
        .rs2                  (rs2),
        .register_data_1      (register_data_1),
        .register_data_2      (register_data_2),
        .write_enable         (write_enable),
        .register_write_select(register_write_select),
        .register_data_write  (register_data_write)
    );

    // Register file stand-in; x0 holds garbage so the zero override is visible.
    function automatic logic [31:0] init_val(input int i);
        return (i == 0) ? 32'hBAD0_BAD0 : (32'hC000_0000 | 32'(i));
    endfunction

    logic [XLEN-1:0] rf [NUM_REGS];
    assign register_data_1 = rf[rs1];
    assign register_data_2 = rf[rs2];

    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= init_val(i);
        end else if (write_enable) begin
            rf[register_write_select] <= register_data_write;
        end
    end

    // Writebacks to a register with no outstanding issue are a protocol error by the producer.
    logic [NUM_REGS-1:0] shadow_pend;
    always @(posedge clock) begin
        if (!reset) begin
            shadow_pend <= '0;
        end else begin
            if (wb_valid && wb_ready && wb_rd != 0 && !shadow_pend[wb_rd])
                $display("protocol note: writeback to x%0d with no pending issue", wb_rd);
            if (write_enable) shadow_pend[register_write_select] <= 1'b0;
            if (issue_valid && issue_ready && issue_writes_rd && issue_rd != 0)
                shadow_pend[issue_rd] <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        issue_valid     = 1'b0;
        issue_rs1       = '0;
        issue_rs2       = '0;
        issue_rd        = '0;
        issue_writes_rd = 1'b0;
        operand_ready   = 1'b1;
        wb_valid        = 1'b0;
        wb_rd           = '0;
        wb_data         = '0;
    endtask

    // ---------------- reference model ----------------
    wb_entry_t       m_q[$];
    logic [31:0]     m_regs [NUM_REGS];
    bit              m_pend [NUM_REGS];
    bit              m_ov;
    logic [31:0]     m_a, m_b;
    logic [4:0]      m_rd;
    logic [4:0]      outstanding[$];

    function automatic logic [31:0] m_val(input logic [4:0] r, input bit we);
        if (r == 0) return '0;
        if (we && m_q[0].rd == r) return m_q[0].data;
        return m_regs[r];
    endfunction

    function automatic bit m_haz(input logic [4:0] r, input bit we);
        return (r != 0) && m_pend[r] && !(we && m_q[0].rd == r);
    endfunction

    task automatic run_random(input int n);
        for (int i = 0; i < NUM_REGS; i++) begin
            m_regs[i] = init_val(i);
            m_pend[i] = 1'b0;
        end
        m_q.delete();
        outstanding.delete();
        m_ov = 1'b0;
        for (int c = 0; c < n; c++) begin
            bit          e_we, e_wbr, e_ir, e_acc;
            logic [31:0] e_a, e_b;
            int          idx;
            idx             = 0;
            issue_valid     = 1'($urandom_range(0, 1));
            issue_rs1       = 5'($urandom_range(0, 7));
            issue_rs2       = 5'($urandom_range(0, 7));
            issue_rd        = 5'($urandom_range(0, 7));
            issue_writes_rd = 1'($urandom_range(0, 1));
            operand_ready   = ($urandom_range(0, 3) != 0);
            wb_valid        = ($urandom_range(0, 2) == 0);
            wb_data         = $urandom;
            if (wb_valid && outstanding.size() > 0) begin
                idx   = $urandom_range(0, outstanding.size() - 1);
                wb_rd = outstanding[idx];
            end else begin
                wb_rd = '0;
            end
            #1;
            e_we  = (m_q.size() != 0);
            e_wbr = (m_q.size() < WB_DEPTH);
            e_ir  = (!m_ov || operand_ready) && !m_haz(issue_rs1, e_we) && !m_haz(issue_rs2, e_we)
                    && !(issue_writes_rd && issue_rd != 0 && m_pend[issue_rd]);
            e_acc = issue_valid && e_ir;
            e_a   = m_val(issue_rs1, e_we);
            e_b   = m_val(issue_rs2, e_we);

            chk("rnd write_enable", 32'(write_enable), 32'(e_we));
            if (e_we) begin
                chk("rnd write_select", 32'(register_write_select), 32'(m_q[0].rd));
                chk("rnd write_data", register_data_write, m_q[0].data);
            end
            chk("rnd wb_ready", 32'(wb_ready), 32'(e_wbr));
            chk("rnd issue_ready", 32'(issue_ready), 32'(e_ir));
            chk("rnd operand_valid", 32'(operand_valid), 32'(m_ov));
            if (m_ov) begin
                chk("rnd operand_a", operand_a, m_a);
                chk("rnd operand_b", operand_b, m_b);
                chk("rnd operand_rd", 32'(operand_rd), 32'(m_rd));
            end

            if (e_we) begin
                m_regs[m_q[0].rd] = m_q[0].data;
                m_pend[m_q[0].rd] = 1'b0;
                void'(m_q.pop_front());
            end
            if (wb_valid && e_wbr && wb_rd != 0) begin
                m_q.push_back('{rd: wb_rd, data: wb_data});
                outstanding.delete(idx);
            end
            if (e_acc) begin
                m_ov = 1'b1;
                m_a  = e_a;
                m_b  = e_b;
                m_rd = issue_rd;
                if (issue_writes_rd && issue_rd != 0) begin
                    m_pend[issue_rd] = 1'b1;
                    outstanding.push_back(issue_rd);
                end
            end else if (operand_ready) begin
                m_ov = 1'b0;
            end
            cyc();
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [4:0]  rs1, rs2;
        logic [31:0] exp_a, exp_b;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{5'd20, 32'hA5A5_A5A5, 5'd20, 5'd0,  32'hA5A5_A5A5, 32'h0};
        vecs[1] = '{5'd21, 32'h0000_0001, 5'd20, 5'd21, 32'hA5A5_A5A5, 32'h1};
        vecs[2] = '{5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0,         32'h0};
        vecs[3] = '{5'd22, 32'h8000_0000, 5'd22, 5'd22, 32'h8000_0000, 32'h8000_0000};
        vecs[4] = '{5'd31, 32'hFFFF_FFFF, 5'd31, 5'd25, 32'hFFFF_FFFF, 32'hC000_0019};

        // 1: reset held three cycles
        reset = 1'b0;
        idle();
        repeat (3) cyc();
        reset = 1'b1;
        #1;
        chk("t1 operand_valid", 32'(operand_valid), 32'd0);
        chk("t1 write_enable", 32'(write_enable), 32'd0);
        chk("t1 wb_ready", 32'(wb_ready), 32'd1);
        chk("t1 issue_ready", 32'(issue_ready), 32'd1);
        chk("t1 operand_a", operand_a, 32'd0);
        cyc();

        run_random(1500);
        idle();
        reset = 1'b0;
        cyc();
        reset = 1'b1;

        for (int v = 0; v < 5; v++) begin
            idle();
            wb_valid = 1'b1;
            wb_rd    = vecs[v].wb_rd;
            wb_data  = vecs[v].wb_data;
            cyc();
            idle();
            cyc();
            issue_valid = 1'b1;
            issue_rs1   = vecs[v].rs1;
            issue_rs2   = vecs[v].rs2;
            #1;
            chk("vec issue_ready", 32'(issue_ready), 32'd1);
            cyc();
            idle();
            #1;
            chk("vec operand_valid", 32'(operand_valid), 32'd1);
            chk("vec operand_a", operand_a, vecs[v].exp_a);
            chk("vec operand_b", operand_b, vecs[v].exp_b);
        end

        // 2: written value read back, x0 reads zero
        idle();
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        #1;
        chk("t2 wb_ready", 32'(wb_ready), 32'd1);
        cyc();
        idle();
        #1;
        chk("t2 write_enable", 32'(write_enable), 32'd1);
        chk("t2 write_select", 32'(register_write_select), 32'd5);
        chk("t2 write_data", register_data_write, 32'hDEAD_BEEF);
        cyc();
        issue_valid = 1'b1; issue_rs1 = 5'd5; issue_rs2 = 5'd0;
        cyc();
        idle();
        #1;
        chk("t2 operand_a", operand_a, 32'hDEAD_BEEF);
        chk("t2 operand_b", operand_b, 32'h0);

        // 3: RAW stall, released and forwarded on the drain cycle
        idle();
        issue_valid = 1'b1; issue_rd = 5'd7; issue_writes_rd = 1'b1;
        #1;
        chk("t3 first issue_ready", 32'(issue_ready), 32'd1);
        cyc();
        issue_rd = '0; issue_writes_rd = 1'b0; issue_rs1 = 5'd7;
        #1;
        chk("t3 raw stall", 32'(issue_ready), 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h12;
        cyc();
        wb_valid = 1'b0;
        #1;
        chk("t3 drain write_enable", 32'(write_enable), 32'd1);
        chk("t3 raw release", 32'(issue_ready), 32'd1);
        cyc();
        idle();
        #1;
        chk("t3 operand_valid", 32'(operand_valid), 32'd1);
        chk("t3 forwarded operand_a", operand_a, 32'h12);
        chk("t3 operand_rd", 32'(operand_rd), 32'd0);

        // 4: WAW on x3 has no same-cycle release
        idle();
        issue_valid = 1'b1; issue_rd = 5'd3; issue_writes_rd = 1'b1;
        cyc();
        #1;
        chk("t4 waw stall", 32'(issue_ready), 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
        cyc();
        wb_valid = 1'b0;
        #1;
        chk("t4 drain select", 32'(register_write_select), 32'd3);
        chk("t4 waw no release", 32'(issue_ready), 32'd0);
        cyc();
        chk("t4 waw cleared", 32'(issue_ready), 32'd1);
        cyc();
        idle();
        issue_valid = 1'b1; issue_rs1 = 5'd3;
        #1;
        chk("t4 pending set again", 32'(issue_ready), 32'd0);
        idle();
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h34;
        cyc();
        idle();
        cyc();

        // 5: back-to-back writebacks drain in order, one per cycle
        operand_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wb_valid = 1'b1; wb_rd = 5'(10 + i); wb_data = 32'h100 + 32'(i);
            #1;
            chk("t5 wb_ready", 32'(wb_ready), 32'd1);
            if (i == 0) begin
                chk("t5 idle write_enable", 32'(write_enable), 32'd0);
            end else begin
                chk("t5 order select", 32'(register_write_select), 32'(9 + i));
                chk("t5 order data", register_data_write, 32'h100 + 32'(i - 1));
            end
            cyc();
        end
        wb_valid = 1'b0;
        #1;
        chk("t5 last select", 32'(register_write_select), 32'd14);
        chk("t5 last data", register_data_write, 32'h104);
        cyc();
        chk("t5 drained", 32'(write_enable), 32'd0);
        issue_valid = 1'b1; issue_rs1 = 5'd10;
        cyc();
        issue_valid = 1'b0; issue_rs1 = 5'd11;
        #1;
        chk("t5 held valid", 32'(operand_valid), 32'd1);
        chk("t5 held operand_a", operand_a, 32'h100);
        chk("t5 slot busy", 32'(issue_ready), 32'd0);
        cyc();
        chk("t5 still held", operand_a, 32'h100);
        operand_ready = 1'b1;
        #1;
        chk("t5 slot freed", 32'(issue_ready), 32'd1);
        cyc();
        chk("t5 bundle taken", 32'(operand_valid), 32'd0);

        // 6: x0 writeback dropped; reset mid-drain discards entry and held bundle
        idle();
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        cyc();
        idle();
        #1;
        chk("t6 x0 dropped", 32'(write_enable), 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd12; wb_data = 32'hABC;
        issue_valid = 1'b1; issue_rs1 = 5'd20; operand_ready = 1'b0;
        cyc();
        idle();
        operand_ready = 1'b0;
        #1;
        chk("t6 held before reset", 32'(operand_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("t6 reset cycle no write", 32'(write_enable), 32'd0);
        cyc();
        reset = 1'b1;
        #1;
        chk("t6 after reset write_enable", 32'(write_enable), 32'd0);
        chk("t6 after reset operand_valid", 32'(operand_valid), 32'd0);
        chk("t6 after reset operand_a", operand_a, 32'd0);
        cyc();
        chk("t6 no late write", 32'(write_enable), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
